// File: rtl/gen_ux_nch.sv
// N-channel phase-accumulator pulse generator with a shared debounced step button and per-channel frequency words.
// Define GEN_UX_AUTOREPEAT_EN to add hold-to-repeat stepping (first repeat after 500 ticks, then every 50).
module gen_ux_nch #(
    parameter int FCLK    = 50_000_000,
    parameter int F_TICK  = 1000,
    parameter int NCE     = 50,
    parameter int NCH     = 4,
    parameter int M       = 100000,
    parameter int ACC_W   = 17,
    parameter int XF_W    = 16,
    parameter int XF_INIT = 49,
    parameter int XF_MIN  = 1,
    parameter int XF_MAX  = M - 1,
    localparam int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW-1:0]   sel,
    input  logic            up,
    input  logic            btn,
    input  logic            load,
    input  logic [XF_W-1:0] load_val,
    output logic            ce1ms,
    output logic            ceo,
    output logic [NCH-1:0]  ux,
    output logic [XF_W-1:0] xf_sel
);
    localparam int DIV = FCLK / F_TICK;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(NCE);

    localparam logic [XF_W-1:0]  XF_MIN_V  = XF_W'(XF_MIN);
    localparam logic [XF_W-1:0]  XF_MAX_V  = XF_W'(XF_MAX);
    localparam logic [XF_W-1:0]  XF_INIT_V = XF_W'(XF_INIT);
    localparam logic [ACC_W-1:0] M_V       = ACC_W'(M);

    logic [TW-1:0]    cnt_t;
    logic [CW-1:0]    cnt_c;
    logic             ce;
    logic             b1;
    logic             b2;
    logic             step;
    logic             rep_step;
    logic             step_any;
    logic [XF_W-1:0]  xf  [NCH];
    logic [ACC_W-1:0] acc [NCH];

    function automatic logic [XF_W-1:0] clamp_xf(input logic [XF_W-1:0] v);
        if (v < XF_MIN_V)
            return XF_MIN_V;
        else if (v > XF_MAX_V)
            return XF_MAX_V;
        else
            return v;
    endfunction

    // Saturating +/-1: a word at its limit holds instead of wrapping.
    function automatic logic [XF_W-1:0] step_xf(input logic [XF_W-1:0] v, input logic dir);
        if (dir)
            return (v >= XF_MAX_V) ? XF_MAX_V : v + XF_W'(1);
        else
            return (v <= XF_MIN_V) ? XF_MIN_V : v - XF_W'(1);
    endfunction

    assign ce1ms    = (cnt_t == TW'(DIV - 1));
    assign ce       = (cnt_c == CW'(NCE - 1));
    assign step     = b1 & ~b2 & ce1ms;
    assign step_any = step | rep_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_t <= '0;
            cnt_c <= '0;
            ceo   <= 1'b0;
            b1    <= 1'b0;
            b2    <= 1'b0;
        end else begin
            cnt_t <= ce1ms ? '0 : cnt_t + TW'(1);
            cnt_c <= ce ? '0 : cnt_c + CW'(1);
            ceo   <= ce;
            if (ce1ms) begin
                b1 <= btn;
                b2 <= b1;
            end
        end
    end

`ifdef GEN_UX_AUTOREPEAT_EN
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [1:0] rstate;
    logic [9:0] rcnt;

    // Release (b1 low) takes priority over a repeat falling on the same tick.
    assign rep_step = ce1ms & b1 &
                      (((rstate == S_DELAY)  && (rcnt == 10'd499)) ||
                       ((rstate == S_REPEAT) && (rcnt == 10'd49)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= S_IDLE;
            rcnt   <= '0;
        end else if (ce1ms) begin
            case (rstate)
                S_IDLE: begin
                    if (step) begin
                        rstate <= S_DELAY;
                        rcnt   <= '0;
                    end
                end
                S_DELAY: begin
                    if (!b1) begin
                        rstate <= S_IDLE;
                    end else if (rcnt == 10'd499) begin
                        rstate <= S_REPEAT;
                        rcnt   <= '0;
                    end else begin
                        rcnt <= rcnt + 10'd1;
                    end
                end
                S_REPEAT: begin
                    if (!b1)
                        rstate <= S_IDLE;
                    else if (rcnt == 10'd49)
                        rcnt <= '0;
                    else
                        rcnt <= rcnt + 10'd1;
                end
                default: rstate <= S_IDLE;
            endcase
        end
    end
`else
    assign rep_step = 1'b0;
`endif

    // Load beats a step landing in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                xf[i] <= XF_INIT_V;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(sel) == i) begin
                    if (load)
                        xf[i] <= clamp_xf(load_val);
                    else if (step_any)
                        xf[i] <= step_xf(xf[i], up);
                end
            end
        end
    end

    // Carry is detected on the pre-update value, so ux lags the overflow by one ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                acc[i] <= '0;
            ux <= '0;
        end else if (ce) begin
            for (int i = 0; i < NCH; i++) begin
                ux[i]  <= (acc[i] >= M_V);
                acc[i] <= (acc[i] >= M_V) ? acc[i] + ACC_W'(xf[i]) - M_V
                                          : acc[i] + ACC_W'(xf[i]);
            end
        end
    end

    always_comb begin
        xf_sel = '0;
        if (int'(sel) < NCH)
            xf_sel = xf[sel];
    end

endmodule

// File: tb/tb_gen_ux_nch.sv
// Bench for gen_ux_nch with small simulation parameters (DIV=10, NCE=4, M=100).
// Carry pulses go through a queue-based scoreboard; xf words are checked against hand-derived values.
module tb_gen_ux_nch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       up = 1'b1;
    logic       btn = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       ce1ms;
    logic       ceo;
    logic [3:0] ux;
    logic [7:0] xf_sel;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];
    bit         sb_on = 1'b0;
    bit         w_on = 1'b0;
    int         pulses = 0;

    gen_ux_nch #(
        .FCLK(1000), .F_TICK(100), .NCE(4), .NCH(4), .M(100), .ACC_W(8),
        .XF_W(8), .XF_INIT(49), .XF_MIN(1), .XF_MAX(99)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .up(up), .btn(btn),
        .load(load), .load_val(load_val), .ce1ms(ce1ms), .ceo(ceo),
        .ux(ux), .xf_sel(xf_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen = 0;
        guard = 0;
        while (seen < n && guard < n * 10 + 20) begin
            @(negedge clk);
            guard++;
            if (ce1ms === 1'b1) seen++;
        end
        if (seen < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_timeout: got %0d ticks, expected %0d", seen, n);
        end
    endtask

    // Press just after a tick edge, hold for 'hold' ticks, release and let the debouncer settle.
    task automatic press(input int hold);
        wait_ticks(1);
        @(negedge clk);
        btn = 1'b1;
        wait_ticks(hold);
        @(negedge clk);
        btn = 1'b0;
        wait_ticks(3);
        @(negedge clk);
    endtask

    task automatic check_xf(input string name, input logic [1:0] ch, input logic [7:0] exp);
        sel = ch;
        #1;
        check(name, xf_sel, exp);
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [7:0] v);
        @(negedge clk);
        sel = ch;
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Reference accumulator for xf=49 on every channel, one entry per ce.
    initial begin
        int mcnt;
        int macc;
        bit co;
        mcnt = 0;
        macc = 0;
        forever begin
            @(posedge clk);
            if (sb_on) begin
                if (mcnt == 3) begin
                    co = (macc >= 100);
                    macc = co ? macc + 49 - 100 : macc + 49;
                    exp_q.push_back(co ? 4'hF : 4'h0);
                end
                mcnt = (mcnt == 3) ? 0 : mcnt + 1;
            end
        end
    end

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (ceo === 1'b1 && (sb_on || exp_q.size() > 0)) begin
                if (exp_q.size() == 0) begin
                    check("ux_sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ux_sb", ux, e);
                    if (ux[0] === 1'b1) pulses++;
                end
            end
        end
    end

    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (w_on) begin
                if (ux[0] === 1'b1) begin
                    run++;
                end else if (run > 0) begin
                    check("ux_width", run, 32'd4);
                    run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ux", ux, 4'h0);
        check("rst_ceo", ceo, 1'b0);
        check("rst_ce1ms", ce1ms, 1'b0);
        check_xf("rst_xf0", 2'd0, 8'd49);

        // tick / ce timing and 100 ce of carry pulses
        rst_n = 1'b1;
        sb_on = 1'b1;
        w_on = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("ce1ms_timing", ce1ms, (k % 10 == 9));
            check("ceo_timing", ceo, (k % 4 == 0));
        end
        repeat (361) @(negedge clk);
        sb_on = 1'b0;
        @(negedge clk);
        w_on = 1'b0;
        check("ux_pulse_count", pulses, 32'd48);
        check("sb_drained", exp_q.size(), 32'd0);

        // single step on channel 2, others untouched, bounce ignored
        sel = 2'd2;
        up = 1'b1;
        press(5);
        check_xf("step_ch2", 2'd2, 8'd50);
        check_xf("other_ch0", 2'd0, 8'd49);
        check_xf("other_ch1", 2'd1, 8'd49);
        check_xf("other_ch3", 2'd3, 8'd49);
        sel = 2'd2;
        wait_ticks(1);
        repeat (3) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        check_xf("bounce_no_step", 2'd2, 8'd50);

        // load clamping and saturation at both limits
        do_load(2'd3, 8'd200);
        check_xf("load_clamp_hi", 2'd3, 8'd99);
        up = 1'b1;
        press(3);
        check_xf("sat_hi", 2'd3, 8'd99);
        do_load(2'd3, 8'd60);
        check_xf("load_mid", 2'd3, 8'd60);
        up = 1'b0;
        press(3);
        check_xf("step_down", 2'd3, 8'd59);
        do_load(2'd3, 8'd0);
        check_xf("load_clamp_lo", 2'd3, 8'd1);
        press(3);
        check_xf("sat_lo", 2'd3, 8'd1);

        // load and step in the same clock on channel 1
        sel = 2'd1;
        up = 1'b1;
        load_val = 8'd10;
        wait_ticks(1);
        @(negedge clk);
        btn = 1'b1;
        wait_ticks(1);
        @(negedge clk);
        wait_ticks(1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        btn = 1'b0;
        check_xf("load_beats_step", 2'd1, 8'd10);
        wait_ticks(3);

        // asynchronous reset while a pulse is showing
        guard = 0;
        while (!(ceo === 1'b1 && ux !== 4'h0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("pulse_before_reset_seen", (guard < 2000), 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ux", ux, 4'h0);
        check("async_rst_ceo", ceo, 1'b0);
        check_xf("async_rst_xf1", 2'd1, 8'd49);
        @(negedge clk);
        sel = 2'd0;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 8) check("post_rst_ceo", ceo, (k % 4 == 0));
            check("post_rst_ux", ux, (k == 16) ? 4'hF : 4'h0);
        end

        // long hold on channel 0
        sel = 2'd0;
        up = 1'b1;
        press(600);
`ifdef GEN_UX_AUTOREPEAT_EN
        check_xf("long_hold", 2'd0, 8'd52);
`else
        check_xf("long_hold", 2'd0, 8'd50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
